// File: rtl/decode_stage.sv
// ============================================================================
// Module      : decode_stage
// Description : MIPS instruction-decode (ID) stage. Holds the 32x32 register
//               file with write-back bypass, the main control decoder,
//               load-use / branch hazard detection, early branch and jump
//               resolution with a one-instruction squash, and the registered
//               ID/EX pipeline register.
// Ports       : i_clock, i_reset       clock, synchronous active-high reset
//               i_valid                 pipeline advance enable
//               i_pc/i_instruction/i_halt  registered outputs of fetch
//               i_wb_*                  register-file write port (WB stage)
//               i_ex_*, i_mem_*         hazard information from EX and MEM
//               o_stall/o_pc_src/o_pc_salto  combinational feedback to fetch
//               o_pc .. o_halt          ID/EX pipeline register
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter int N_BITS     = 32,
    parameter int N_BITS_REG = 5,
    parameter int N_REGS     = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [N_BITS-1:0]     i_pc,
    input  logic [N_BITS-1:0]     i_instruction,
    input  logic                  i_halt,
    input  logic                  i_wb_reg_write,
    input  logic [N_BITS_REG-1:0] i_wb_addr,
    input  logic [N_BITS-1:0]     i_wb_data,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    input  logic [N_BITS_REG-1:0] i_ex_wr_addr,
    input  logic                  i_mem_mem_read,
    input  logic [N_BITS_REG-1:0] i_mem_wr_addr,
    output logic                  o_stall,
    output logic                  o_pc_src,
    output logic [N_BITS-1:0]     o_pc_salto,
    output logic [N_BITS-1:0]     o_pc,
    output logic [N_BITS-1:0]     o_rs_data,
    output logic [N_BITS-1:0]     o_rt_data,
    output logic [N_BITS-1:0]     o_imm,
    output logic [N_BITS_REG-1:0] o_rs,
    output logic [N_BITS_REG-1:0] o_rt,
    output logic [N_BITS_REG-1:0] o_rd,
    output logic [5:0]            o_funct,
    output logic                  o_reg_write,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    output logic                  o_mem_to_reg,
    output logic                  o_alu_src,
    output logic                  o_reg_dst,
    output logic                  o_halt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]            opcode;
    logic [N_BITS_REG-1:0] rs;
    logic [N_BITS_REG-1:0] rt;
    logic [N_BITS_REG-1:0] rd;
    logic [5:0]            funct;
    logic [N_BITS-1:0]     imm_ext;

    assign opcode  = i_instruction[31:26];
    assign rs      = i_instruction[25:21];
    assign rt      = i_instruction[20:16];
    assign rd      = i_instruction[15:11];
    assign funct   = i_instruction[5:0];
    assign imm_ext = {{(N_BITS-16){i_instruction[15]}}, i_instruction[15:0]};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [N_BITS-1:0] regs [N_REGS];
    logic [N_BITS-1:0] rs_data;
    logic [N_BITS-1:0] rt_data;

    // Register 0 is never written, so it keeps its reset value; reads of
    // index 0 are forced to zero anyway.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (i_wb_reg_write && (i_wb_addr != '0)) begin
            regs[i_wb_addr] <= i_wb_data;
        end
    end

    // A write-back landing in the same cycle is forwarded so ID never
    // sees a stale operand.
    always_comb begin
        rs_data = '0;
        if (rs != '0) begin
            if (i_wb_reg_write && (i_wb_addr == rs)) begin
                rs_data = i_wb_data;
            end else begin
                rs_data = regs[rs];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (rt != '0) begin
            if (i_wb_reg_write && (i_wb_addr == rt)) begin
                rt_data = i_wb_data;
            end else begin
                rt_data = regs[rt];
            end
        end
    end

    // ------------------------------------------------------------------
    // Main control decoder
    // ------------------------------------------------------------------
    logic dec_reg_write;
    logic dec_mem_read;
    logic dec_mem_write;
    logic dec_mem_to_reg;
    logic dec_alu_src;
    logic dec_reg_dst;
    logic is_beq;
    logic is_bne;
    logic is_j;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_dst    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_reg_dst   = 1'b1;
            end
            OP_LW: begin
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
                dec_alu_src    = 1'b1;
            end
            OP_SW: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            OP_ADDI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
            end
            default: begin
                // Branches, jumps and unknown opcodes carry no EX control.
            end
        endcase
    end

    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_j   = (opcode == OP_J);

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic load_use;
    logic branch_hazard;
    logic ex_match;
    logic mem_match;
    logic flush;

    assign ex_match  = (i_ex_wr_addr != '0) &&
                       ((i_ex_wr_addr == rs) || (i_ex_wr_addr == rt));
    assign mem_match = (i_mem_wr_addr != '0) &&
                       ((i_mem_wr_addr == rs) || (i_mem_wr_addr == rt));

    assign load_use = i_ex_mem_read && ex_match;

    // Branches compare in ID, so any producer still in EX (ALU result not
    // yet available) or a load in MEM must drain first.
    assign branch_hazard = (is_beq || is_bne) &&
                           ((i_ex_reg_write && ex_match) ||
                            (i_mem_mem_read && mem_match));

    // Gated by reset so fetch sees a quiet ID stage while reset is held.
    assign o_stall = !i_reset && i_valid && !flush && (load_use || branch_hazard);

    // ------------------------------------------------------------------
    // Early branch / jump resolution
    // ------------------------------------------------------------------
    logic              operands_equal;
    logic              branch_taken;
    logic [N_BITS-1:0] branch_target;
    logic [N_BITS-1:0] jump_target;

    assign operands_equal = (rs_data == rt_data);
    assign branch_taken   = (is_beq && operands_equal) || (is_bne && !operands_equal);
    assign branch_target  = i_pc + N_BITS'(1) + imm_ext;
    assign jump_target    = {i_pc[N_BITS-1:26], i_instruction[25:0]};

    assign o_pc_salto = is_j ? jump_target : branch_target;
    assign o_pc_src   = !i_reset && i_valid && !o_stall && !flush &&
                        (branch_taken || is_j);

    // ------------------------------------------------------------------
    // Squash flag and ID/EX pipeline register
    // ------------------------------------------------------------------
    // flush marks the instruction fetched behind a redirect; it is consumed
    // by the next valid cycle, which is exactly the one to squash.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            flush        <= 1'b0;
            o_pc         <= '0;
            o_rs_data    <= '0;
            o_rt_data    <= '0;
            o_imm        <= '0;
            o_rs         <= '0;
            o_rt         <= '0;
            o_rd         <= '0;
            o_funct      <= '0;
            o_reg_write  <= 1'b0;
            o_mem_read   <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_to_reg <= 1'b0;
            o_alu_src    <= 1'b0;
            o_reg_dst    <= 1'b0;
            o_halt       <= 1'b0;
        end else if (i_valid) begin
            flush <= o_pc_src;
            if (o_stall || flush || o_halt) begin
                // Bubble; o_halt is left untouched so it stays sticky.
                o_pc         <= '0;
                o_rs_data    <= '0;
                o_rt_data    <= '0;
                o_imm        <= '0;
                o_rs         <= '0;
                o_rt         <= '0;
                o_rd         <= '0;
                o_funct      <= '0;
                o_reg_write  <= 1'b0;
                o_mem_read   <= 1'b0;
                o_mem_write  <= 1'b0;
                o_mem_to_reg <= 1'b0;
                o_alu_src    <= 1'b0;
                o_reg_dst    <= 1'b0;
            end else begin
                o_pc         <= i_pc;
                o_rs_data    <= rs_data;
                o_rt_data    <= rt_data;
                o_imm        <= imm_ext;
                o_rs         <= rs;
                o_rt         <= rt;
                o_rd         <= rd;
                o_funct      <= funct;
                o_reg_write  <= dec_reg_write;
                o_mem_read   <= dec_mem_read;
                o_mem_write  <= dec_mem_write;
                o_mem_to_reg <= dec_mem_to_reg;
                o_alu_src    <= dec_alu_src;
                o_reg_dst    <= dec_reg_dst;
                o_halt       <= i_halt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. A table of per-cycle
//               stimulus records with expected feedback signals and expected
//               ID/EX content drives the DUT; ID/EX expectations go through a
//               one-deep scoreboard queue and are compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}
    localparam logic [5:0] C_R    = 6'b100001;
    localparam logic [5:0] C_LW   = 6'b110110;
    localparam logic [5:0] C_SW   = 6'b001010;
    localparam logic [5:0] C_ADDI = 6'b100010;
    localparam logic [5:0] C_NONE = 6'b000000;

    typedef logic [155:0] idex_t;

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        ex_rw;
        logic        ex_mr;
        logic [4:0]  ex_addr;
        logic        mem_mr;
        logic [4:0]  mem_addr;
        logic        e_stall;
        logic        e_pc_src;
        logic [31:0] e_salto;
        logic        e_bubble;
        logic [5:0]  e_ctrl;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic        e_halt;
    } vec_t;

    logic        i_clock, i_reset, i_valid, i_halt;
    logic [31:0] i_pc, i_instruction, i_wb_data;
    logic        i_wb_reg_write, i_ex_reg_write, i_ex_mem_read, i_mem_mem_read;
    logic [4:0]  i_wb_addr, i_ex_wr_addr, i_mem_wr_addr;
    logic        o_stall, o_pc_src;
    logic [31:0] o_pc_salto, o_pc, o_rs_data, o_rt_data, o_imm;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic [5:0]  o_funct;
    logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst;
    logic        o_halt;

    decode_stage dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_valid        (i_valid),
        .i_pc           (i_pc),
        .i_instruction  (i_instruction),
        .i_halt         (i_halt),
        .i_wb_reg_write (i_wb_reg_write),
        .i_wb_addr      (i_wb_addr),
        .i_wb_data      (i_wb_data),
        .i_ex_reg_write (i_ex_reg_write),
        .i_ex_mem_read  (i_ex_mem_read),
        .i_ex_wr_addr   (i_ex_wr_addr),
        .i_mem_mem_read (i_mem_mem_read),
        .i_mem_wr_addr  (i_mem_wr_addr),
        .o_stall        (o_stall),
        .o_pc_src       (o_pc_src),
        .o_pc_salto     (o_pc_salto),
        .o_pc           (o_pc),
        .o_rs_data      (o_rs_data),
        .o_rt_data      (o_rt_data),
        .o_imm          (o_imm),
        .o_rs           (o_rs),
        .o_rt           (o_rt),
        .o_rd           (o_rd),
        .o_funct        (o_funct),
        .o_reg_write    (o_reg_write),
        .o_mem_read     (o_mem_read),
        .o_mem_write    (o_mem_write),
        .o_mem_to_reg   (o_mem_to_reg),
        .o_alu_src      (o_alu_src),
        .o_reg_dst      (o_reg_dst),
        .o_halt         (o_halt)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    idex_t act_idex;
    assign act_idex = {o_pc, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd, o_funct,
                       o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src,
                       o_reg_dst, o_halt};

    int    n_checks = 0;
    int    n_fail   = 0;
    idex_t sb[$];
    idex_t last_exp;
    vec_t  tab[$];

    task automatic check(input string name, input idex_t act, input idex_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] f);
        return {6'b0, rs, rt, rd, 5'b0, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] tgt);
        return {OP_J, tgt};
    endfunction

    function automatic vec_t nrm(input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [5:0] ctrl, input logic [31:0] rsd,
                                 input logic [31:0] rtd);
        vec_t v;
        v        = '0;
        v.valid  = 1'b1;
        v.pc     = pc;
        v.instr  = instr;
        v.e_ctrl = ctrl;
        v.e_rs   = rsd;
        v.e_rt   = rtd;
        return v;
    endfunction

    function automatic vec_t bub(input logic [31:0] pc, input logic [31:0] instr);
        vec_t v;
        v          = nrm(pc, instr, C_NONE, 32'h0, 32'h0);
        v.e_bubble = 1'b1;
        return v;
    endfunction

    // Expected ID/EX content for a record, independent of the DUT.
    function automatic idex_t exp_of(input vec_t v);
        if (v.e_bubble) return {155'b0, v.e_halt};
        return {v.pc, v.e_rs, v.e_rt, {{16{v.instr[15]}}, v.instr[15:0]},
                v.instr[25:21], v.instr[20:16], v.instr[15:11], v.instr[5:0],
                v.e_ctrl, v.e_halt};
    endfunction

    task automatic drive(input vec_t v);
        i_valid        = v.valid;
        i_halt         = v.halt;
        i_pc           = v.pc;
        i_instruction  = v.instr;
        i_wb_reg_write = v.wb_we;
        i_wb_addr      = v.wb_addr;
        i_wb_data      = v.wb_data;
        i_ex_reg_write = v.ex_rw;
        i_ex_mem_read  = v.ex_mr;
        i_ex_wr_addr   = v.ex_addr;
        i_mem_mem_read = v.mem_mr;
        i_mem_wr_addr  = v.mem_addr;
    endtask

    task automatic apply(input vec_t v, input string tag);
        idex_t e;
        @(negedge i_clock);
        drive(v);
        #1;
        check({tag, " stall"}, idex_t'(o_stall), idex_t'(v.e_stall));
        check({tag, " pc_src"}, idex_t'(o_pc_src), idex_t'(v.e_pc_src));
        if (v.e_pc_src) check({tag, " pc_salto"}, idex_t'(o_pc_salto), idex_t'(v.e_salto));
        if (v.valid) last_exp = exp_of(v);
        sb.push_back(last_exp);
        @(posedge i_clock);
        #1;
        e = sb.pop_front();
        check({tag, " idex"}, act_idex, e);
    endtask

    initial begin
        vec_t v;

        // ---------------- stimulus table ----------------
        v = nrm(0, enc_r(0, 0, 0, 6'h20), C_R, 0, 0);
        v.wb_we = 1; v.wb_addr = 5; v.wb_data = 32'h1234;              tab.push_back(v);
        v = nrm(1, enc_r(5, 0, 6, 6'h20), C_R, 32'h1234, 0);           tab.push_back(v);
        v = nrm(2, enc_r(7, 5, 8, 6'h22), C_R, 32'h55, 32'h1234);
        v.wb_we = 1; v.wb_addr = 7; v.wb_data = 32'h55;                 tab.push_back(v);
        v = nrm(3, enc_r(0, 7, 9, 6'h20), C_R, 0, 32'h55);
        v.wb_we = 1; v.wb_addr = 0; v.wb_data = 32'hDEAD;               tab.push_back(v);
        v = nrm(4, enc_r(0, 0, 1, 6'h20), C_R, 0, 0);                   tab.push_back(v);
        v = nrm(5, enc_i(OP_LW, 2, 3, 16'h0004), C_LW, 0, 0);
        v.wb_we = 1; v.wb_addr = 1; v.wb_data = 32'd7;                  tab.push_back(v);
        v = nrm(6, enc_i(OP_SW, 1, 2, 16'hFFF8), C_SW, 7, 7);
        v.wb_we = 1; v.wb_addr = 2; v.wb_data = 32'd7;                  tab.push_back(v);
        // load-use stall, then the same instruction decodes normally
        v = bub(7, enc_r(3, 2, 4, 6'h20));
        v.ex_rw = 1; v.ex_mr = 1; v.ex_addr = 3; v.e_stall = 1;         tab.push_back(v);
        v = nrm(7, enc_r(3, 2, 4, 6'h20), C_R, 32'h33, 7);
        v.mem_mr = 1; v.mem_addr = 3;
        v.wb_we = 1; v.wb_addr = 3; v.wb_data = 32'h33;                 tab.push_back(v);
        v = nrm(8, enc_i(OP_ADDI, 1, 10, 16'h8000), C_ADDI, 7, 0);      tab.push_back(v);
        // BEQ taken backward, then squash (hazard inputs ignored while squashing)
        v = nrm(10, enc_i(OP_BEQ, 1, 2, 16'hFFFD), C_NONE, 7, 7);
        v.e_pc_src = 1; v.e_salto = 32'd8;                              tab.push_back(v);
        v = bub(11, enc_r(1, 2, 11, 6'h20));
        v.ex_mr = 1; v.ex_addr = 1;                                     tab.push_back(v);
        v = nrm(8, enc_i(OP_BNE, 1, 2, 16'hFFFD), C_NONE, 7, 7);        tab.push_back(v);
        v = nrm(9, enc_i(OP_BNE, 1, 3, 16'h0005), C_NONE, 7, 32'h33);
        v.e_pc_src = 1; v.e_salto = 32'd15;                             tab.push_back(v);
        v = bub(16, enc_j(26'h20));                                     tab.push_back(v);
        // branch operand produced in EX
        v = bub(20, enc_i(OP_BEQ, 1, 2, 16'h0002));
        v.ex_rw = 1; v.ex_addr = 1; v.e_stall = 1;                      tab.push_back(v);
        v = nrm(20, enc_i(OP_BEQ, 1, 2, 16'h0002), C_NONE, 7, 7);
        v.e_pc_src = 1; v.e_salto = 32'd23;                             tab.push_back(v);
        v = bub(21, enc_r(1, 2, 11, 6'h20));                            tab.push_back(v);
        // branch operand loaded in MEM
        v = bub(30, enc_i(OP_BEQ, 1, 2, 16'h0000));
        v.mem_mr = 1; v.mem_addr = 2; v.e_stall = 1;                    tab.push_back(v);
        v = nrm(30, enc_i(OP_BEQ, 1, 2, 16'h0000), C_NONE, 7, 7);
        v.e_pc_src = 1; v.e_salto = 32'd31;                             tab.push_back(v);
        v = bub(31, enc_r(1, 2, 11, 6'h20));                            tab.push_back(v);
        // load to r0 never stalls
        v = nrm(40, enc_r(0, 0, 12, 6'h20), C_R, 0, 0);
        v.ex_mr = 1; v.ex_addr = 0;                                     tab.push_back(v);
        // jump, an idle cycle, then the squashed slot
        v = nrm(32'h4000_0010, enc_j(26'h0000020), C_NONE, 0, 0);
        v.e_pc_src = 1; v.e_salto = 32'h4000_0020;                      tab.push_back(v);
        v = nrm(32'h4000_0011, enc_r(1, 2, 3, 6'h20), C_R, 7, 7);
        v.valid = 0;                                                    tab.push_back(v);
        v = bub(32'h4000_0011, enc_i(OP_SW, 1, 2, 16'h0004));           tab.push_back(v);
        v = nrm(50, enc_i(6'h3F, 1, 2, 16'h1111), C_NONE, 7, 7);        tab.push_back(v);
        v = nrm(51, enc_i(OP_ADDI, 1, 14, 16'h0001), C_ADDI, 7, 0);
        v.ex_rw = 1; v.ex_addr = 1;                                     tab.push_back(v);
        // halt latches and sticks
        v = nrm(60, enc_r(0, 0, 0, 6'h20), C_R, 0, 0);
        v.halt = 1; v.e_halt = 1;                                       tab.push_back(v);
        v = bub(61, enc_r(1, 2, 13, 6'h20));
        v.e_halt = 1;                                                   tab.push_back(v);

        // ---------------- reset ----------------
        i_reset = 1'b1;
        drive('0);
        repeat (2) @(posedge i_clock);
        @(negedge i_clock);
        check("reset stall", idex_t'(o_stall), '0);
        check("reset pc_src", idex_t'(o_pc_src), '0);
        sb.push_back('0);
        check("reset idex", act_idex, sb.pop_front());
        i_reset  = 1'b0;
        last_exp = '0;

        // ---------------- table ----------------
        for (int i = 0; i < tab.size(); i++) begin
            apply(tab[i], $sformatf("row%0d", i));
        end

        // ---------------- reset in the middle of a stall ----------------
        v = bub(70, enc_r(3, 2, 4, 6'h20));
        v.ex_mr = 1; v.ex_addr = 3; v.e_stall = 1; v.e_halt = 1;
        apply(v, "pre_reset");
        @(negedge i_clock);
        i_reset = 1'b1;
        #1;
        check("mid_reset stall", idex_t'(o_stall), '0);
        check("mid_reset pc_src", idex_t'(o_pc_src), '0);
        @(posedge i_clock);
        #1;
        sb.push_back('0);
        check("mid_reset idex", act_idex, sb.pop_front());
        @(negedge i_clock);
        i_reset = 1'b0;
        // r5 must have been cleared and halt released
        v = nrm(71, enc_r(5, 1, 6, 6'h20), C_R, 0, 0);
        apply(v, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
MIPS ID stage, directly downstream of the fetch stage; consumes its registered PC, instruction and halt outputs. Contains the 32x32 register file, main control decoder, load-use/branch hazard detection and early branch/jump resolution. It drives the stall and redirect signals back to fetch and presents a registered ID/EX pipeline register to execute.

Parameters:
N_BITS, 32, datapath/instruction width
N_BITS_REG, 5, register index width
N_REGS, 32, register file depth

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_valid  in  1  pipeline advance enable
i_pc  in  N_BITS  word address of instruction in ID (from fetch)
i_instruction  in  N_BITS  instruction from fetch
i_halt  in  1  halt flag from fetch
i_wb_reg_write  in  1  WB write enable
i_wb_addr  in  N_BITS_REG  WB destination
i_wb_data  in  N_BITS  WB data
i_ex_reg_write  in  1  EX-stage instr writes a reg
i_ex_mem_read  in  1  EX-stage instr is LW
i_ex_wr_addr  in  N_BITS_REG  EX-stage destination
i_mem_mem_read  in  1  MEM-stage instr is LW
i_mem_wr_addr  in  N_BITS_REG  MEM-stage destination
o_stall  out  1  combinational; holds fetch PC and IF output
o_pc_src  out  1  combinational; redirect fetch
o_pc_salto  out  N_BITS  redirect target
o_pc, o_rs_data, o_rt_data, o_imm  out  N_BITS  ID/EX: PC, operands, sign-extended imm
o_rs, o_rt, o_rd  out  N_BITS_REG  ID/EX register indices
o_funct  out  6  ID/EX funct
o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst  out  1 each  ID/EX control
o_halt  out  1  ID/EX halt, sticky

Behaviour:
- Reset: all outputs 0, all 32 registers 0, flush flag 0. Reset has priority over everything, also mid-stall.
- Regfile: write on posedge when i_wb_reg_write && i_wb_addr!=0 (independent of i_valid); reg 0 reads 0 always. Read is combinational with WB bypass: same-cycle WB to the read address returns i_wb_data (except addr 0).
- Decode (opcode=instr[31:26]): R-type 000000 -> reg_write, reg_dst; LW 100011 -> reg_write, mem_read, mem_to_reg, alu_src; SW 101011 -> mem_write, alu_src; ADDI 001000 -> reg_write, alu_src; BEQ 000100 / BNE 000101 / J 000010 -> no ID/EX control. Unknown opcode -> all control 0.
- Load-use stall: i_ex_mem_read && i_ex_wr_addr!=0 && (i_ex_wr_addr==rs || i_ex_wr_addr==rt).
- Branch stall (BEQ/BNE only): (i_ex_reg_write && i_ex_wr_addr!=0 && matches rs/rt) || (i_mem_mem_read && i_mem_wr_addr!=0 && matches rs/rt).
- o_stall = i_valid && !flush && (load-use || branch stall).
- Branch: equality on bypassed operands; taken = (BEQ&&eq)||(BNE&&!eq); target = i_pc + 1 + sign_ext(instr[15:0]) mod 2^32. J: target = {i_pc[31:26], instr[25:0]}. o_pc_src = i_valid && !o_stall && !flush && (taken||J). o_pc_salto is always driven with the computed target; it is don't-care when o_pc_src=0.
- Flush: the posedge where o_pc_src=1 sets flush. The next valid cycle's instruction is squashed (bubble, no o_pc_src, no stall); flush then clears. Exactly one instruction is squashed.
- ID/EX update on posedge when i_valid: on stall or flush, load a bubble (all control 0, indices 0, o_halt unchanged). Otherwise latch the decode and operands; o_imm = sign_ext(instr[15:0]), o_rd = instr[15:11]. i_valid=0 holds all outputs.
- o_halt is set when an unsquashed, unstalled i_halt is latched. It stays set until reset; while set, ID/EX loads only bubbles.
- Latency: 1 cycle from instruction presented to ID/EX outputs.

Test Plan:
1. Reset, then write r5=0x1234 via WB -> ADD rs=5 next cycle gives o_rs_data=0x1234; WB r5 in same cycle as read -> bypassed value; WB to r0 -> reads 0.
2. EX LW r3 (i_ex_mem_read=1, addr 3) with ID "add r4,r3,r2" -> o_stall=1 for one cycle, ID/EX bubble (o_reg_write=0); next cycle normal decode.
3. BEQ r1,r2 with r1=r2=7, i_pc=10, imm=-3 -> o_pc_src=1, o_pc_salto=8; next instruction squashed into bubble; BNE same operands -> o_pc_src=0.
4. BEQ with i_ex_reg_write=1, i_ex_wr_addr=rs -> stall 1 cycle, then resolves. MEM LW to rt -> same stall.
5. J at i_pc=0x40000010, target field 0x0000020 -> o_pc_salto=0x40000020, o_pc_src=1.
6. i_halt=1 -> o_halt=1 next posedge and sticky. i_reset asserted mid-stall -> all outputs 0 and o_stall deasserted next cycle.
